// File: rtl/conv_pkg.sv
// conv_pkg: shared states, generator defaults and the code-pair function for conv_encoder
package conv_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ENC = 2'd1, DONE = 2'd2} state_t;
  localparam int K = 3;
  localparam logic [2:0] G0_DEF = 3'b111;
  localparam logic [2:0] G1_DEF = 3'b101;
  // generator bit 2 taps u, bit 1 taps s1, bit 0 taps s2; result is {c0, c1}
  function automatic logic [1:0] enc_pair(input logic u, input logic s1, input logic s2,
                                          input logic [2:0] g0 = G0_DEF,
                                          input logic [2:0] g1 = G1_DEF);
    enc_pair = {(g0[2] & u) ^ (g0[1] & s1) ^ (g0[0] & s2),
                (g1[2] & u) ^ (g1[1] & s1) ^ (g1[0] & s2)};
  endfunction
endpackage

// File: rtl/conv_encoder_if.sv
// conv_encoder_if: start/message request and coded-result bundle of conv_encoder
interface conv_encoder_if #(parameter int MAX_BITS = 7);
  logic enable;
  logic [MAX_BITS-1:0] dstring;
  logic [2:0] size;
  logic [2*MAX_BITS-1:0] rstring;
  logic busy;
  logic done;
  modport master(output enable, dstring, size, input rstring, busy, done);
  modport slave(input enable, dstring, size, output rstring, busy, done);
endinterface

// File: rtl/conv_enc_core.sv
// conv_enc_core: K=3 shift register and combinational code pair for the current input bit
module conv_enc_core
  import conv_pkg::*;
#(
  parameter logic [2:0] G0 = G0_DEF,
  parameter logic [2:0] G1 = G1_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       u,
  input  logic       shift,
  input  logic       clear,
  output logic [1:0] code
);
  logic s1, s2;
  assign code = enc_pair(u, s1, s2, G0, G1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else if (clear) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else if (shift) begin
      s2 <= s1;
      s1 <= u;
    end
  end
endmodule

// File: rtl/conv_encoder.sv
// conv_encoder: bit-serial rate-1/2 K=3 convolutional encoder producing a 2*MAX_BITS coded string
module conv_encoder
  import conv_pkg::*;
#(
  parameter int         MAX_BITS = 7,
  parameter logic [2:0] G0 = G0_DEF,
  parameter logic [2:0] G1 = G1_DEF
) (
  input logic clk,
  input logic rst,
  conv_encoder_if.slave bus
);
  localparam int CW = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_ENC = ENC;
  localparam logic [1:0] ST_DONE = DONE;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [MAX_BITS-1:0] msg;
  logic [2:0] sz, sz_in;
  logic [2*MAX_BITS-1:0] rstring;
  logic [1:0] code;
  logic start, last;
  assign sz_in = (int'(bus.size) > MAX_BITS) ? 3'(MAX_BITS) : bus.size;
  assign start = (state == ST_IDLE) && bus.enable;
  assign last = int'(cnt) == int'(sz) - 1;
  assign bus.rstring = rstring;
  assign bus.busy = state != ST_IDLE;
  assign bus.done = state == ST_DONE;
  conv_enc_core #(.G0(G0), .G1(G1)) core (
    .clk(clk),
    .rst(rst),
    .u(msg[cnt]),
    .shift(state == ST_ENC),
    .clear(start),
    .code(code)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      msg <= '0;
      sz <= '0;
      rstring <= '0;
    end else if (start) begin
      msg <= bus.dstring;
      sz <= sz_in;
      cnt <= '0;
      rstring <= '0;
      state <= (sz_in != 3'd0) ? ST_ENC : ST_DONE;
    end else if (state == ST_ENC) begin
      rstring[{cnt, 1'b0} +: 2] <= code;
      cnt <= cnt + 1'b1;
      state <= last ? ST_DONE : ST_ENC;
    end else if (state == ST_DONE) begin
      state <= ST_IDLE;
    end
  end
endmodule

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder: table, hand-written and random checks of conv_encoder against a message-level model
module tb_conv_encoder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  conv_encoder_if #(.MAX_BITS(7)) bus ();
  conv_encoder dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [6:0]  msg;
    logic [2:0]  size;
    logic [13:0] exp;
  } vec_t;

  // each output pair depends on the current bit and the two previous message bits
  function automatic logic [13:0] ref_enc(input logic [6:0] m, input int n);
    logic [13:0] r = '0;
    for (int i = 0; i < n; i++) begin
      logic p1 = (i >= 1) ? m[i-1] : 1'b0;
      logic p2 = (i >= 2) ? m[i-2] : 1'b0;
      r[2*i+1] = m[i] ^ p1 ^ p2;
      r[2*i]   = m[i] ^ p2;
    end
    return r;
  endfunction

  // recovers the message from the second code bit of each pair, as a receiver would
  function automatic logic [6:0] inv_dec(input logic [13:0] r, input int n);
    logic [6:0] m = '0;
    for (int i = 0; i < n; i++)
      m[i] = r[2*i] ^ ((i >= 2) ? m[i-2] : 1'b0);
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_job(input string name, input logic [6:0] m, input logic [2:0] n, input logic [13:0] exp);
    int k;
    int busy_cycles = 0;
    bit seen = 0;
    @(negedge clk);
    check({name, " idle busy"}, 32'(bus.busy), 0);
    bus.enable = 1'b1;
    bus.dstring = m;
    bus.size = n;
    @(posedge clk);
    #1 bus.enable = 1'b0;
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.busy) busy_cycles++;
      if (bus.done) begin
        seen = 1;
        break;
      end
    end
    check({name, " done seen"}, 32'(seen), 1);
    check({name, " latency"}, k, int'(n) + 1);
    check({name, " busy cycles"}, busy_cycles, int'(n) + 1);
    check({name, " rstring"}, 32'(bus.rstring), 32'(exp));
    check({name, " decode"}, 32'(inv_dec(bus.rstring, int'(n))), 32'(m & 7'((1 << n) - 1)));
    @(negedge clk);
    check({name, " done pulse"}, 32'(bus.done), 0);
    check({name, " back idle"}, 32'(bus.busy), 0);
  endtask

  vec_t tv[5];

  initial begin
    logic [6:0] m;
    logic [2:0] n;
    logic [13:0] held;
    int k;
    tv[0] = '{7'b0001011, 3'd4, 14'h0017};
    tv[1] = '{7'b1111011, 3'd4, 14'h0017};
    tv[2] = '{7'b0000001, 3'd1, 14'h0003};
    tv[3] = '{7'h7F,      3'd7, 14'h2AA7};
    tv[4] = '{7'h55,      3'd0, 14'h0000};
    bus.enable = 1'b0;
    bus.dstring = '0;
    bus.size = '0;
    #2;
    check("reset rstring", 32'(bus.rstring), 0);
    check("reset busy", 32'(bus.busy), 0);
    check("reset done", 32'(bus.done), 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) run_job($sformatf("vec%0d", i), tv[i].msg, tv[i].size, tv[i].exp);

    held = bus.rstring;
    repeat (3) @(negedge clk);
    check("idle hold", 32'(bus.rstring), 32'(held));

    // enable held high: second job starts after exactly one idle cycle
    @(negedge clk);
    bus.enable = 1'b1;
    bus.dstring = 7'b0000101;
    bus.size = 3'd3;
    @(posedge clk);
    #1 bus.dstring = 7'b0000110;
    k = 0;
    while (!bus.done && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("b2b first", 32'(bus.rstring), 32'(ref_enc(7'b0000101, 3)));
    @(negedge clk);
    check("b2b idle gap", 32'(bus.busy), 0);
    @(negedge clk);
    check("b2b restart", 32'(bus.busy), 1);
    bus.enable = 1'b0;
    k = 0;
    while (!bus.done && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("b2b second", 32'(bus.rstring), 32'(ref_enc(7'b0000110, 3)));
    check("b2b second latency", k, 3);

    // asynchronous reset mid-encode
    @(negedge clk);
    bus.enable = 1'b1;
    bus.dstring = 7'h7F;
    bus.size = 3'd7;
    @(posedge clk);
    #1 bus.enable = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort rstring", 32'(bus.rstring), 0);
    check("abort busy", 32'(bus.busy), 0);
    check("abort done", 32'(bus.done), 0);
    @(negedge clk);
    rst = 1'b1;
    run_job("after abort", 7'b0001011, 3'd4, 14'h0017);

    for (int i = 0; i < 30; i++) begin
      m = 7'($urandom);
      n = 3'($urandom_range(0, 7));
      run_job($sformatf("rand%0d", i), m, n, ref_enc(m, int'(n)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
